// File: rtl/boton_cmd_scheduler.sv
// boton_cmd_scheduler: debounces front-panel buttons and round-robin schedules one command channel
//   clk       : single clock, all logic on posedge
//   reset     : synchronous, active-high
//   botones   : raw asynchronous button levels
//   switches  : operand/opcode switches, captured when a button is granted
//   cmd_ready : consumer accepts the command on the current edge
//   ovr_clr   : clears all overrun flags
//   cmd_valid : command available
//   cmd_id    : index of the granted button
//   cmd_data  : switches captured at grant
//   pending   : registered pending-request flags
//   overrun   : sticky, a press was lost while its request was still pending
module boton_cmd_scheduler #(
   parameter int N_BTN      = 4,
   parameter int DEB_CYCLES = 4,
   parameter int DATA_W     = 8,
   parameter int ID_W       = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_BTN-1:0]  botones,
   input  logic [DATA_W-1:0] switches,
   input  logic              cmd_ready,
   input  logic              ovr_clr,
   output logic              cmd_valid,
   output logic [ID_W-1:0]   cmd_id,
   output logic [DATA_W-1:0] cmd_data,
   output logic [N_BTN-1:0]  pending,
   output logic [N_BTN-1:0]  overrun
);
   typedef enum logic {IDLE, VALID} state_t;
   localparam logic [ID_W-1:0] LAST = ID_W'(N_BTN - 1);
   state_t state, stateNext;
   logic [N_BTN-1:0] rise, grantVec;
   logic [ID_W-1:0] ptr, grantIdx, cand;
   logic found, grant;
   genvar i;
   for (i = 0; i < N_BTN; i++) begin : gDeb
      logic s1, s2, lvl;
      logic [DEB_CYCLES-1:0] hist;
      // level only changes on a full run of equal samples, so short bounces hold the old level
      always_ff @(posedge clk) begin
         if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= '0;
            lvl  <= 1'b0;
         end else begin
            s1   <= botones[i];
            s2   <= s1;
            hist <= {hist[DEB_CYCLES-2:0], s2};
            lvl  <= (&hist) ? 1'b1 : (~|hist) ? 1'b0 : lvl;
         end
      end
      // fires combinationally so pending is set on the same edge lvl rises
      assign rise[i] = ~lvl & (&hist);
   end
   // first pending index after the last grant, wrapping around
   always_comb begin
      found    = 1'b0;
      grantIdx = '0;
      cand     = '0;
      for (int k = 1; k <= N_BTN; k++) begin
         cand = ID_W'((int'(ptr) + k) % N_BTN);
         if (!found && pending[cand]) begin
            found    = 1'b1;
            grantIdx = cand;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= LAST;
         cmd_id   <= '0;
         cmd_data <= '0;
         pending  <= '0;
         overrun  <= '0;
      end else begin
         state <= stateNext;
         if (grant) begin
            ptr      <= grantIdx;
            cmd_id   <= grantIdx;
            cmd_data <= switches;
         end
         // an event coinciding with its own grant re-arms the request without loss
         pending <= (pending & ~grantVec) | rise;
         overrun <= (overrun & ~{N_BTN{ovr_clr}}) | (rise & pending & ~grantVec);
      end
   end
   always_comb begin
      stateNext = state == IDLE ? (found ? VALID : IDLE) : (cmd_ready ? IDLE : VALID);
   end
   always_comb begin
      cmd_valid = state == VALID;
      grant     = state == IDLE && found;
      grantVec  = grant ? N_BTN'(1) << grantIdx : '0;
   end
endmodule

// File: tb/tb_boton_cmd_scheduler.sv
// tb_boton_cmd_scheduler: directed scenarios plus randomized run against a behavioural model
module tb_boton_cmd_scheduler;
   localparam int N = 4, D = 4, W = 8, IW = 2;
   logic clk = 1'b0, reset = 1'b1, cmd_ready = 1'b0, ovr_clr = 1'b0;
   logic [N-1:0] botones = '0;
   logic [W-1:0] switches = '0;
   logic cmd_valid;
   logic [IW-1:0] cmd_id;
   logic [W-1:0] cmd_data;
   logic [N-1:0] pending, overrun;
   int checks = 0, errors = 0;
   boton_cmd_scheduler #(.N_BTN(N), .DEB_CYCLES(D), .DATA_W(W), .ID_W(IW)) dut (
      .clk(clk), .reset(reset), .botones(botones), .switches(switches),
      .cmd_ready(cmd_ready), .ovr_clr(ovr_clr), .cmd_valid(cmd_valid),
      .cmd_id(cmd_id), .cmd_data(cmd_data), .pending(pending), .overrun(overrun)
   );
   always #5 clk = ~clk;
   // model: raw[k] is the button sample taken k+1 edges ago; a level is accepted once
   // the D samples that have crossed the two synchronizer stages all agree
   logic [N-1:0] raw [D+2];
   logic [N-1:0] mLvl, mPend, mOvr, mRise, mGrant;
   logic mValid;
   logic [IW-1:0] mId, mPtr;
   logic [W-1:0] mData;
   int gi, ones;
   always @(posedge clk) begin
      if (reset) begin
         mLvl = '0; mPend = '0; mOvr = '0; mValid = 1'b0; mId = '0; mData = '0;
         mPtr = IW'(N - 1);
         for (int k = 0; k < D + 2; k++) raw[k] = '0;
      end else begin
         mRise = '0;
         for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int k = 2; k < D + 2; k++) ones += int'(raw[k][b]);
            if (ones == D && !mLvl[b]) begin mRise[b] = 1'b1; mLvl[b] = 1'b1; end
            else if (ones == 0) mLvl[b] = 1'b0;
         end
         gi = -1;
         if (!mValid)
            for (int k = 1; k <= N; k++)
               if (gi < 0 && mPend[(int'(mPtr) + k) % N]) gi = (int'(mPtr) + k) % N;
         mGrant = '0;
         if (gi >= 0) mGrant[gi] = 1'b1;
         mOvr = (ovr_clr ? '0 : mOvr) | (mRise & mPend & ~mGrant);
         mPend = (mPend & ~mGrant) | mRise;
         if (mValid) begin
            if (cmd_ready) mValid = 1'b0;
         end else if (gi >= 0) begin
            mValid = 1'b1; mId = IW'(gi); mData = switches; mPtr = IW'(gi);
         end
         for (int k = D + 1; k > 0; k--) raw[k] = raw[k-1];
         raw[0] = botones;
      end
   end
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1'b1; cmd_ready = 1'b0; ovr_clr = 1'b0; botones = '0;
      tick(); tick();
      reset = 1'b0;
   endtask
   task automatic test_reset();
      reset = 1'b1; botones = 4'b1111; switches = 8'hFF; cmd_ready = 1'b1; ovr_clr = 1'b0;
      tick(); tick();
      checks++;
      if ({cmd_valid, cmd_id, cmd_data, pending, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b_%h_%h_%b_%b required all zero", cmd_valid, cmd_id, cmd_data, pending, overrun);
      end
      botones = '0; cmd_ready = 1'b0;
   endtask
   task automatic test_single_press();
      reset = 1'b1; botones = 4'b0001; switches = 8'hA5; cmd_ready = 1'b0;
      tick();
      reset = 1'b0;
      repeat (6) tick();
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("FAIL t1_pending_edge6 got %b required 0000", pending); end
      tick();
      checks++;
      if ({cmd_valid, pending} !== 5'b0_0001) begin errors++; $display("FAIL t1_pending_edge7 got %b/%b required 0/0001", cmd_valid, pending); end
      tick();
      checks++;
      if ({cmd_valid, cmd_id, cmd_data, pending} !== {1'b1, 2'd0, 8'hA5, 4'b0000}) begin
         errors++;
         $display("FAIL t1_grant_edge8 got v=%b id=%0d d=%h p=%b required v=1 id=0 d=a5 p=0000", cmd_valid, cmd_id, cmd_data, pending);
      end
      switches = 8'h3C;
      repeat (3) begin
         tick();
         checks++;
         if ({cmd_valid, cmd_id, cmd_data} !== {1'b1, 2'd0, 8'hA5}) begin
            errors++;
            $display("FAIL t1_hold got v=%b id=%0d d=%h required v=1 id=0 d=a5", cmd_valid, cmd_id, cmd_data);
         end
      end
      cmd_ready = 1'b1;
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL t1_accept got v=%b required 0", cmd_valid); end
      cmd_ready = 1'b0; botones = '0;
   endtask
   task automatic test_bounce();
      logic [6:0] seq;
      seq = 7'b0110101;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         botones = c < 7 ? {2'b00, seq[c], 1'b0} : 4'b0000;
         tick();
         checks++;
         if ({cmd_valid, pending} !== 5'b0) begin
            errors++;
            $display("FAIL t2_bounce cycle %0d got v=%b p=%b required v=0 p=0000", c, cmd_valid, pending);
         end
      end
   endtask
   task automatic test_multi_press();
      int ids[$], cyc[$];
      do_reset();
      botones = 4'b1101; cmd_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (cmd_valid) begin ids.push_back(int'(cmd_id)); cyc.push_back(c); end
         checks++;
         if ({cmd_valid, cmd_id, cmd_data, pending, overrun} !== {mValid, mId, mData, mPend, mOvr}) begin
            errors++;
            $display("FAIL t3_model got %b_%h_%h_%b_%b required %b_%h_%h_%b_%b", cmd_valid, cmd_id, cmd_data, pending, overrun, mValid, mId, mData, mPend, mOvr);
         end
      end
      checks++;
      if (ids.size() != 3 || ids[0] != 0 || ids[1] != 2 || ids[2] != 3) begin
         errors++;
         $display("FAIL t3_order got %0d grants (%p) required ids 0,2,3", ids.size(), ids);
      end else begin
         checks++;
         if (cyc[1] - cyc[0] != 2 || cyc[2] - cyc[1] != 2) begin
            errors++;
            $display("FAIL t3_spacing got cycles %p required 2 apart", cyc);
         end
      end
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("FAIL t3_pending_end got %b required 0000", pending); end
      botones = '0; cmd_ready = 1'b0;
      repeat (10) tick();
   endtask
   task automatic test_wraparound();
      int ids[$];
      do_reset();
      botones = 4'b0100; cmd_ready = 1'b1;
      repeat (12) tick();
      botones = 4'b0000;
      repeat (10) tick();
      botones = 4'b1001;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (cmd_valid) ids.push_back(int'(cmd_id));
      end
      checks++;
      if (ids.size() != 2 || ids[0] != 3 || ids[1] != 0) begin
         errors++;
         $display("FAIL t4_wrap got %0d grants (%p) required ids 3,0", ids.size(), ids);
      end
      botones = '0; cmd_ready = 1'b0;
      repeat (10) tick();
   endtask
   task automatic test_overrun();
      do_reset();
      switches = 8'h5A;
      botones = 4'b0010; repeat (10) tick();
      checks++;
      if ({cmd_valid, cmd_id, cmd_data, pending} !== {1'b1, 2'd1, 8'h5A, 4'b0000}) begin
         errors++;
         $display("FAIL t5_first got v=%b id=%0d d=%h p=%b required v=1 id=1 d=5a p=0000", cmd_valid, cmd_id, cmd_data, pending);
      end
      botones = 4'b0000; repeat (10) tick();
      botones = 4'b0010; repeat (10) tick();
      checks++;
      if ({pending, overrun} !== 8'b0010_0000) begin errors++; $display("FAIL t5_second got p=%b o=%b required p=0010 o=0000", pending, overrun); end
      botones = 4'b0000; repeat (10) tick();
      botones = 4'b0010; repeat (10) tick();
      checks++;
      if ({pending, overrun} !== 8'b0010_0010) begin errors++; $display("FAIL t5_third got p=%b o=%b required p=0010 o=0010", pending, overrun); end
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      checks++;
      if ({cmd_valid, overrun} !== 5'b1_0000) begin errors++; $display("FAIL t5_clear got v=%b o=%b required v=1 o=0000", cmd_valid, overrun); end
      botones = '0;
   endtask
   task automatic test_reset_midway();
      do_reset();
      botones = 4'b0111;
      repeat (10) tick();
      checks++;
      if ({cmd_valid, cmd_id, pending} !== {1'b1, 2'd0, 4'b0110}) begin
         errors++;
         $display("FAIL t6_before got v=%b id=%0d p=%b required v=1 id=0 p=0110", cmd_valid, cmd_id, pending);
      end
      reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if ({cmd_valid, pending, overrun} !== 9'b0) begin
         errors++;
         $display("FAIL t6_after_reset got v=%b p=%b o=%b required all zero", cmd_valid, pending, overrun);
      end
      repeat (6) tick();
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("FAIL t6_edge6 got p=%b required 0000", pending); end
      tick();
      checks++;
      if ({cmd_valid, pending} !== 5'b0_0111) begin errors++; $display("FAIL t6_edge7 got v=%b p=%b required v=0 p=0111", cmd_valid, pending); end
      tick();
      checks++;
      if ({cmd_valid, cmd_id, pending} !== {1'b1, 2'd0, 4'b0110}) begin
         errors++;
         $display("FAIL t6_regrant got v=%b id=%0d p=%b required v=1 id=0 p=0110", cmd_valid, cmd_id, pending);
      end
      botones = '0;
   endtask
   task automatic test_random();
      logic [N-1:0] target;
      target = '0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 23) == 0) target[b] = ~target[b];
            botones[b] = $urandom_range(0, 5) == 0 ? ~target[b] : target[b];
         end
         switches  = W'($urandom);
         cmd_ready = $urandom_range(0, 2) != 0;
         ovr_clr   = $urandom_range(0, 19) == 0;
         reset     = $urandom_range(0, 699) == 0;
         tick();
         checks++;
         if ({cmd_valid, cmd_id, cmd_data, pending, overrun} !== {mValid, mId, mData, mPend, mOvr}) begin
            errors++;
            $display("FAIL random_model cycle %0d got %b_%h_%h_%b_%b required %b_%h_%h_%b_%b", c, cmd_valid, cmd_id, cmd_data, pending, overrun, mValid, mId, mData, mPend, mOvr);
         end
      end
      reset = 1'b0; ovr_clr = 1'b0;
   endtask
   initial begin
      @(negedge clk);
      test_reset();
      test_single_press();
      test_bounce();
      test_multi_press();
      test_wraparound();
      test_overrun();
      test_reset_midway();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
